uart_rx_core: RTL and testbench

- UART receiver with an integrated baud-tick generator: a 16x oversampling tick divider plus an 8N1 receive state machine.
- Converts the asynchronous serial line i_rx into a parallel byte and raises a one-cycle done strobe per frame.
- Sits between the board RX pin and the byte-consuming logic (e.g. ALU/interface FSM) of the UART subsystem.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_core.sv | 135 +++++++++++++
 tb/tb_uart_rx_core.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the RX state encoding and the baud divider arithmetic.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int calc_div(
        input int clk_freq,
        input int baud_rate,
        input int oversample
    );
        return clk_freq / (baud_rate * oversample);
    endfunction

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator.
// Emits a one-cycle pulse every DIV clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 325,
    parameter int CW  = cnt_width(DIV)
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with integrated 16x baud tick generator.
// Define UART_RX_FRAME_ERR_EN to add the o_frame_err output.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int NB_BITS    = 8,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx,
    output logic [NB_BITS-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_tick
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic               o_frame_err
`endif
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW   = cnt_width(DIV);
    localparam int SMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NB_BITS - 1);

    logic               tick;
    logic [1:0]         sync;
    logic               rx;
    rx_state_t          state;
    logic [SW-1:0]      s;
    logic [NW-1:0]      n;
    logic [NB_BITS-1:0] sreg;

    uart_baud_tick #(
        .DIV (DIV),
        .CW  (CW)
    ) u_tick (
        .clk   (i_clk),
        .rst_n (i_rst),
        .tick  (tick)
    );

    assign o_tick = tick;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], i_rx};
        end
    end

    assign rx = sync[1];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            sreg      <= '0;
            o_data    <= '0;
            o_rx_done <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            o_frame_err <= 1'b0;
`endif
        end else begin
            o_rx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        // Mid start bit: a high line here was a glitch.
                        if (s == S_MID) begin
                            if (rx) begin
                                state <= IDLE;
                            end else begin
                                s     <= '0;
                                n     <= '0;
                                state <= DATA;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s    <= '0;
                            sreg <= {rx, sreg[NB_BITS-1:1]};
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP) begin
                            o_data    <= sreg;
                            o_rx_done <= 1'b1;
                            state     <= IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                            o_frame_err <= !rx;
`endif
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a fast-baud instance for framing
// plus a default-parameter instance for the 325-clock tick period.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic [7:0] data_def;
    logic       done;
    logic       done_def;
    logic       tick;
    logic       tick_def;
`ifdef UART_RX_FRAME_ERR_EN
    logic       ferr;
    logic       ferr_def;
`endif

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_done = 0;
    int prev_done = 0;

    uart_rx_core #(
        .CLK_FREQ  (1_600_000),
        .BAUD_RATE (10_000)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_rx      (rx),
        .o_data    (data),
        .o_rx_done (done),
        .o_tick    (tick)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .o_frame_err (ferr)
`endif
    );

    uart_rx_core dut_def (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_rx      (rx),
        .o_data    (data_def),
        .o_rx_done (done_def),
        .o_tick    (tick_def)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .o_frame_err (ferr_def)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (done) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clks(BIT);
        end
        rx = stop;
        if (stop) begin
            clks(BIT);
        end else begin
            clks(100);
            rx = 1'b1;
            clks(60);
        end
        rx = 1'b1;
    endtask

    task automatic measure(input bit def, output int per);
        int t0;
        for (int i = 0; i < 1000; i++) begin
            if (def ? tick_def : tick) break;
            @(negedge clk);
        end
        t0 = cyc;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            if (def ? tick_def : tick) break;
            @(negedge clk);
        end
        per = cyc - t0;
    endtask

    initial begin
        int p;
        int n0;
        logic [7:0] ab;
        ab = 8'hC6;

        rx = 1'b1;
        rst_n = 1'b0;
        clks(3);
        check("rst_data", data, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_tick_def", tick_def, 1'b0);
`ifdef UART_RX_FRAME_ERR_EN
        check("rst_ferr", ferr, 1'b0);
`endif
        rst_n = 1'b1;

        measure(1'b0, p);
        check("tick_period", p, 10);
        measure(1'b1, p);
        check("tick_period_def", p, 325);
        clks(50);

        n0 = done_cnt;
        send_frame(8'h51, 1'b1);
        clks(BIT);
        check("f51_count", done_cnt, n0 + 1);
        check("f51_data", data, 8'h51);

        rx = 1'b0;
        clks(40);
        rx = 1'b1;
        clks(3 * BIT);
        check("glitch_count", done_cnt, n0 + 1);
        check("glitch_data", data, 8'h51);

        n0 = done_cnt;
        send_frame(8'h55, 1'b1);
        check("b2b55_count", done_cnt, n0 + 1);
        check("b2b55_data", data, 8'h55);
        send_frame(8'hA3, 1'b1);
        check("b2bA3_count", done_cnt, n0 + 2);
        check("b2bA3_data", data, 8'hA3);
        check("b2b_spacing", last_done - prev_done, 10 * BIT);
        clks(BIT);

        n0 = done_cnt;
        send_frame(8'h51, 1'b0);
        clks(BIT);
        check("stop0_count", done_cnt, n0 + 1);
        check("stop0_data", data, 8'h51);
`ifdef UART_RX_FRAME_ERR_EN
        check("stop0_ferr", ferr, 1'b1);
`endif
        send_frame(8'h3C, 1'b1);
        clks(BIT);
        check("good_count", done_cnt, n0 + 2);
        check("good_data", data, 8'h3C);
`ifdef UART_RX_FRAME_ERR_EN
        check("good_ferr", ferr, 1'b0);
`endif

        n0 = done_cnt;
        rx = 1'b0;
        clks(BIT);
        for (int i = 0; i < 3; i++) begin
            rx = ab[i];
            clks(BIT);
        end
        rx = ab[3];
        clks(80);
        rst_n = 1'b0;
        clks(2);
        check("midrst_data", data, 8'h00);
        check("midrst_done", done, 1'b0);
        rx = 1'b1;
        clks(20);
        rst_n = 1'b1;
        clks(400);
        check("midrst_count", done_cnt, n0);
        send_frame(8'h0F, 1'b1);
        clks(BIT);
        check("f0F_count", done_cnt, n0 + 1);
        check("f0F_data", data, 8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
